app_mul_pipe: RTL and testbench

- Parametrised, handshaked successor of the fixed 9-bit approximate multiplier used in the LIF neuron datapath.
- Computes an unsigned product of two WIDTH-bit operands per transaction, selectable per transaction:
  - mode=0: Mitchell logarithmic approximation.
  - mode=1: exact product.
- Two-stage valid/ready pipeline with full backpressure; result is saturated to OUT_W bits.
- Sits between the synaptic-weight path and the membrane accumulator.

---
 rtl/app_mul_pipe_if.sv | 26 ++
 rtl/app_mul_pipe.sv | 130 +++++++++++++
 tb/tb_app_mul_pipe.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/app_mul_pipe_if.sv
// Handshake bundle for app_mul_pipe: operand channel in, product channel out.
// The master drives operands and out_ready; the slave (the multiplier) drives the rest.
interface app_mul_pipe_if #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned OUT_W = 2 * WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out;
  logic             out_sat;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, out, out_sat
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, out, out_sat
  );
endinterface

// File: rtl/app_mul_pipe.sv
// Two-stage valid/ready unsigned multiplier: Mitchell log approximation (mode=0) or exact
// product (mode=1), saturated to OUT_W bits.
module app_mul_pipe #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned OUT_W = 2 * WIDTH
) (
  input logic           clk,
  input logic           rst_n,
  app_mul_pipe_if.slave bus
);
  localparam int unsigned F  = WIDTH - 1;
  localparam int unsigned KW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned IW = 2 * WIDTH + F;

  function automatic logic [KW-1:0] lead_one(input logic [WIDTH-1:0] v);
    logic [KW-1:0] k;
    k = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (v[i]) k = KW'(i);
    end
    return k;
  endfunction

  // Shift the leading one up to bit F; the bits below it are the left-aligned fraction.
  function automatic logic [F-1:0] frac(input logic [WIDTH-1:0] v, input logic [KW-1:0] k);
    logic [WIDTH-1:0] sh;
    sh = v << (KW'(F) - k);
    return sh[F-1:0];
  endfunction

  // Handshake
  logic s1_v_q, s2_v_q;
  logic s2_free, s1_move, in_ready, accept;

  assign s2_free  = !s2_v_q || bus.out_ready;
  assign s1_move  = s1_v_q && s2_free;
  assign in_ready = !s1_v_q || !s2_v_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_v_q;

  // Stage 1 next-state
  logic [KW-1:0] ka_d, kb_d;
  logic [F:0]    s_d;
  logic          z_d;
  logic [PW-1:0] p_d;

  always_comb begin
    ka_d = lead_one(bus.a);
    kb_d = lead_one(bus.b);
    s_d  = {1'b0, frac(bus.a, ka_d)} + {1'b0, frac(bus.b, kb_d)};
    z_d  = (bus.a == '0) || (bus.b == '0);
    p_d  = PW'(bus.a) * PW'(bus.b);
  end

  logic [KW-1:0] ka_q, kb_q;
  logic [F:0]    s_q;
  logic          z_q;
  logic [PW-1:0] p_q;
  logic          mode_q;

  // Stage 2 combinational result
  logic [KW:0]      sh_amt;
  logic [IW-1:0]    mant, r_apx, r;
  logic             sat_d;
  logic [OUT_W-1:0] out_d;

  always_comb begin
    // A fraction carry bumps the exponent; the mantissa keeps only the low F bits either way.
    sh_amt = {1'b0, ka_q} + {1'b0, kb_q} + {{KW{1'b0}}, s_q[F]};
    mant   = IW'({1'b1, s_q[F-1:0]});
    r_apx  = (mant << sh_amt) >> F;
    if (z_q) begin
      r = '0;
    end else if (mode_q) begin
      r = IW'(p_q);
    end else begin
      r = r_apx;
    end
    sat_d = |r[IW-1:OUT_W];
    out_d = sat_d ? '1 : r[OUT_W-1:0];
  end

  logic [OUT_W-1:0] out_q;
  logic             sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      ka_q   <= '0;
      kb_q   <= '0;
      s_q    <= '0;
      z_q    <= 1'b0;
      p_q    <= '0;
      mode_q <= 1'b0;
      out_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      if (accept) begin
        ka_q   <= ka_d;
        kb_q   <= kb_d;
        s_q    <= s_d;
        z_q    <= z_d;
        p_q    <= p_d;
        mode_q <= bus.mode;
      end

      if (accept) begin
        s1_v_q <= 1'b1;
      end else if (s1_move) begin
        s1_v_q <= 1'b0;
      end

      if (s1_move) begin
        s2_v_q <= 1'b1;
        out_q  <= out_d;
        sat_q  <= sat_d;
      end else if (bus.out_ready) begin
        s2_v_q <= 1'b0;
      end
    end
  end

  assign bus.out     = out_q;
  assign bus.out_sat = sat_q;

endmodule

// File: tb/tb_app_mul_pipe.sv
// Scoreboard bench for app_mul_pipe: directed products, backpressure, a random stream with
// random valid/ready, mid-stream reset, and a narrow OUT_W=12 instance for saturation.
module tb_app_mul_pipe;
  localparam int unsigned W  = 9;
  localparam int unsigned OW = 2 * W;
  localparam int unsigned F  = W - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  app_mul_pipe_if #(.WIDTH(W), .OUT_W(OW)) bus ();
  app_mul_pipe #(.WIDTH(W), .OUT_W(OW)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  app_mul_pipe_if #(.WIDTH(W), .OUT_W(12)) bus12 ();
  app_mul_pipe #(.WIDTH(W), .OUT_W(12)) u_dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12));

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint mitchell(input longint a, input longint b);
    int ka, kb;
    longint xa, xb, s, one_f;
    if (a == 0 || b == 0) return 0;
    ka = 0;
    kb = 0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) ka = i;
      if (b[i]) kb = i;
    end
    one_f = longint'(1) << F;
    xa = (a - (longint'(1) << ka)) << (F - ka);
    xb = (b - (longint'(1) << kb)) << (F - kb);
    s  = xa + xb;
    if (s < one_f) return ((one_f + s) << (ka + kb)) >> F;
    return (s << (ka + kb + 1)) >> F;
  endfunction

  typedef struct {
    longint val;
    bit     sat;
    longint prod;
    bit     m;
    int     c;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t predict(input longint a, input longint b, input bit m, input int c);
    exp_t   e;
    longint r;
    r = m ? a * b : mitchell(a, b);
    e.sat  = (r >= (longint'(1) << OW));
    e.val  = e.sat ? ((longint'(1) << OW) - 1) : r;
    e.prod = a * b;
    e.m    = m;
    e.c    = c;
    return e;
  endfunction

  bit               check_lat = 1'b0;
  bit               held      = 1'b0;
  logic [OW-1:0]    hold_out;
  logic             hold_sat;
  logic [OW-1:0]    last_out;
  logic             last_sat;
  int               n_out = 0;
  exp_t             e_mon;

  // Pop before push: an output can never belong to the transaction accepted this cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        check_eq("hold_valid", 64'(bus.out_valid), 64'd1);
        check_eq("hold_out", 64'(bus.out), 64'(hold_out));
        check_eq("hold_sat", 64'(bus.out_sat), 64'(hold_sat));
      end
      held = 1'b0;
      if (bus.out_valid) begin
        if (!bus.out_ready) begin
          held     = 1'b1;
          hold_out = bus.out;
          hold_sat = bus.out_sat;
        end else if (sb.size() == 0) begin
          check_eq("spurious_out", 64'd1, 64'd0);
        end else begin
          e_mon = sb.pop_front();
          check_eq("out", 64'(bus.out), 64'(e_mon.val));
          check_eq("out_sat", 64'(bus.out_sat), 64'(e_mon.sat));
          if (!e_mon.m) check_eq("apx_le_exact", 64'(64'(bus.out) <= 64'(e_mon.prod)), 64'd1);
          if (check_lat) check_eq("latency", 64'(cyc - e_mon.c), 64'd2);
          last_out = bus.out;
          last_sat = bus.out_sat;
          n_out++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(predict(longint'(bus.a), longint'(bus.b), bus.mode, cyc));
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit m);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.mode     = m;
    @(negedge clk);
    while (!bus.in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check_eq("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      check_eq("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input bit m,
                          input longint exp);
    send(a, b, m);
    drain();
    check_eq("dir_out", 64'(last_out), 64'(exp));
    check_eq("dir_sat", 64'(last_sat), 64'd0);
  endtask

  task automatic send12(input logic [W-1:0] a, input logic [W-1:0] b, input bit m,
                        input longint exp, input bit exp_sat);
    int n = 0;
    bus12.in_valid = 1'b1;
    bus12.a        = a;
    bus12.b        = b;
    bus12.mode     = m;
    @(negedge clk);
    while (!bus12.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus12.in_valid = 1'b0;
    n = 0;
    while (!bus12.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("w12_valid", 64'(bus12.out_valid), 64'd1);
    check_eq("w12_out", 64'(bus12.out), 64'(exp));
    check_eq("w12_sat", 64'(bus12.out_sat), 64'(exp_sat));
  endtask

  bit done = 1'b0;
  int n_start;

  initial begin
    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.mode        = 1'b0;
    bus.out_ready   = 1'b1;
    bus12.in_valid  = 1'b0;
    bus12.a         = '0;
    bus12.b         = '0;
    bus12.mode      = 1'b0;
    bus12.out_ready = 1'b1;

    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_out", 64'(bus.out), 64'd0);
    check_eq("rst_out_sat", 64'(bus.out_sat), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Directed, no stall: latency is checked on each result
    check_lat = 1'b1;
    directed(9'd3, 9'd3, 1'b0, 8);
    directed(9'd5, 9'd6, 1'b0, 28);
    directed(9'd255, 9'd255, 1'b0, 65024);
    directed(9'd256, 9'd256, 1'b0, 65536);
    directed(9'd1, 9'd1, 1'b0, 1);
    directed(9'd255, 9'd255, 1'b1, 65025);
    directed(9'd511, 9'd511, 1'b1, 261121);
    directed(9'd0, 9'd511, 1'b0, 0);
    directed(9'd511, 9'd0, 1'b0, 0);

    send12(9'd255, 9'd255, 1'b1, 4095, 1'b1);
    send12(9'd63, 9'd1, 1'b0, 63, 1'b0);

    // Backpressure: two held in the pipe, third blocked, output held for 4 cycles
    check_lat     = 1'b0;
    n_start       = n_out;
    bus.out_ready = 1'b0;
    send(9'd10, 9'd20, 1'b0);
    send(9'd30, 9'd40, 1'b1);
    bus.in_valid = 1'b1;
    bus.a        = 9'd50;
    bus.b        = 9'd60;
    bus.mode     = 1'b0;
    @(negedge clk);
    check_eq("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check_eq("bp_out_valid", 64'(bus.out_valid), 64'd1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send(9'd50, 9'd60, 1'b0);
    send(9'd70, 9'd80, 1'b1);
    send(9'd90, 9'd100, 1'b0);
    drain();
    check_eq("bp_count", 64'(n_out - n_start), 64'd5);

    // Random stream
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          while ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(($urandom_range(15) == 0) ? 9'd0 : W'($urandom_range(511)),
               ($urandom_range(15) == 0) ? 9'd0 : W'($urandom_range(511)),
               1'($urandom_range(1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    // Mid-stream reset with two transactions in flight
    bus.out_ready = 1'b0;
    send(9'd7, 9'd9, 1'b1);
    send(9'd11, 9'd13, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("mid_rst_out", 64'(bus.out), 64'd0);
    check_eq("mid_rst_out_sat", 64'(bus.out_sat), 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_eq("post_rst_idle", 64'(bus.out_valid), 64'd0);
    end
    check_lat = 1'b1;
    directed(9'd5, 9'd6, 1'b0, 28);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
